// File: rtl/alu_result_capture.sv
// ALU result capture: compacts valid-strobed ALU outputs into a 32-bit MISR signature
// and counts Zero/Sign flag hits over a run of iCount samples.
module alu_result_capture #(
   parameter logic [31:0] POLY  = 32'h04C11DB7,
   parameter logic [31:0] SEED  = 32'h00000000,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iStart,
   input  logic [CNT_W-1:0] iCount,
   input  logic             iValid,
   input  logic [31:0]      iX,
   input  logic             iZero,
   input  logic             iSign,
   input  logic [3:0]       iAluOp,
   output logic             oBusy,
   output logic             oDone,
   output logic [31:0]      oSig,
   output logic [CNT_W-1:0] oZeroCnt,
   output logic [CNT_W-1:0] oSignCnt,
   output logic [CNT_W-1:0] oSamples
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [1:0]       r_state;
   logic [31:0]      r_sig;
   logic [CNT_W-1:0] r_zero_cnt;
   logic [CNT_W-1:0] r_sign_cnt;
   logic [CNT_W-1:0] r_samples;
   logic [CNT_W-1:0] r_remaining;

   logic             w_accept;
   logic             w_capture;
   logic             w_last;
   logic [31:0]      w_data;
   logic [31:0]      w_sig_next;

   assign w_accept   = iStart && (r_state != ST_CAPTURE);
   assign w_capture  = iValid && (r_state == ST_CAPTURE);
   assign w_last     = (r_remaining == CNT_W'(1));
   assign w_data     = iX ^ {iAluOp, 26'b0, iSign, iZero};
   // Galois MISR: shift left, fold the polynomial in when the MSB falls off
   assign w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sig       <= SEED;
         r_zero_cnt  <= '0;
         r_sign_cnt  <= '0;
         r_samples   <= '0;
         r_remaining <= '0;
      end else if (w_accept) begin
         r_state     <= (iCount == '0) ? ST_DONE : ST_CAPTURE;
         r_sig       <= SEED;
         r_zero_cnt  <= '0;
         r_sign_cnt  <= '0;
         r_samples   <= '0;
         r_remaining <= iCount;
      end else if (w_capture) begin
         r_sig       <= w_sig_next;
         r_zero_cnt  <= r_zero_cnt + CNT_W'(iZero);
         r_sign_cnt  <= r_sign_cnt + CNT_W'(iSign);
         r_samples   <= r_samples + CNT_W'(1);
         r_remaining <= r_remaining - CNT_W'(1);
         if (w_last) begin
            r_state <= ST_DONE;
         end
      end
   end

   assign oBusy    = (r_state == ST_CAPTURE);
   assign oDone    = (r_state == ST_DONE);
   assign oSig     = r_sig;
   assign oZeroCnt = r_zero_cnt;
   assign oSignCnt = r_sign_cnt;
   assign oSamples = r_samples;

endmodule

// File: tb/tb_alu_result_capture.sv
// Bench for alu_result_capture: directed runs with known signatures, then random traffic
// checked every cycle against a run-level reference model.
module tb_alu_result_capture;

   localparam logic [31:0] POLY  = 32'h04C11DB7;
   localparam logic [31:0] SEED  = 32'h00000000;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             iStart;
   logic [CNT_W-1:0] iCount;
   logic             iValid;
   logic [31:0]      iX;
   logic             iZero;
   logic             iSign;
   logic [3:0]       iAluOp;
   logic             oBusy;
   logic             oDone;
   logic [31:0]      oSig;
   logic [CNT_W-1:0] oZeroCnt;
   logic [CNT_W-1:0] oSignCnt;
   logic [CNT_W-1:0] oSamples;

   alu_result_capture #(
      .POLY (POLY),
      .SEED (SEED),
      .CNT_W(CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .iStart  (iStart),
      .iCount  (iCount),
      .iValid  (iValid),
      .iX      (iX),
      .iZero   (iZero),
      .iSign   (iSign),
      .iAluOp  (iAluOp),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oSig    (oSig),
      .oZeroCnt(oZeroCnt),
      .oSignCnt(oSignCnt),
      .oSamples(oSamples)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a run is "active" while samples are still owed
   bit          m_active;
   bit          m_done;
   int unsigned m_left;
   logic [31:0] m_sig;
   int unsigned m_zero;
   int unsigned m_sign;
   int unsigned m_samples;

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
      logic [31:0] fb;
      fb = s[31] ? POLY : 32'h0;
      return (s << 1) ^ fb ^ d;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_active = 0; m_done = 0; m_left = 0; m_sig = SEED;
         m_zero = 0; m_sign = 0; m_samples = 0;
      end else if (iStart && !m_active) begin
         m_sig = SEED; m_zero = 0; m_sign = 0; m_samples = 0;
         m_left   = iCount;
         m_active = (iCount != 0);
         m_done   = (iCount == 0);
      end else if (m_active && iValid) begin
         m_sig = misr(m_sig, iX ^ {iAluOp, 26'b0, iSign, iZero});
         m_zero += iZero;
         m_sign += iSign;
         m_samples++;
         m_left--;
         if (m_left == 0) begin
            m_active = 0;
            m_done   = 1;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".busy"},    32'(oBusy),    32'(m_active));
      chk({tag, ".done"},    32'(oDone),    32'(m_done));
      chk({tag, ".sig"},     oSig,          m_sig);
      chk({tag, ".zero"},    32'(oZeroCnt), m_zero);
      chk({tag, ".sign"},    32'(oSignCnt), m_sign);
      chk({tag, ".samples"}, 32'(oSamples), m_samples);
   endtask

   task automatic idle_inputs();
      iStart = 0; iValid = 0; iX = '0; iZero = 0; iSign = 0; iAluOp = '0;
   endtask

   task automatic start_run(input int unsigned n);
      idle_inputs();
      iStart = 1; iCount = CNT_W'(n);
      iValid = 1; iX = 32'hDEADBEEF;  // must not be captured in the start cycle
      tick();
      idle_inputs();
   endtask

   task automatic sample(input logic [31:0] x, input logic z, input logic s, input logic [3:0] op);
      iValid = 1; iX = x; iZero = z; iSign = s; iAluOp = op;
      tick();
      idle_inputs();
   endtask

   initial begin
      rst = 1; iCount = '0;
      idle_inputs();
      tick(); tick();
      rst = 0;
      check_all("reset");
      chk("reset.sig_seed", oSig, SEED);

      // 1: simple shift
      start_run(2);
      check_all("t1.start");
      sample(32'h1, 0, 0, 4'h0);
      chk("t1.sig1", oSig, 32'h1);
      sample(32'h0, 0, 0, 4'h0);
      chk("t1.sig2", oSig, 32'h2);
      chk("t1.done", 32'(oDone), 32'd1);
      chk("t1.samples", 32'(oSamples), 32'd2);
      check_all("t1.end");

      // 2: feedback path
      start_run(2);
      sample(32'h80000000, 0, 0, 4'h0);
      sample(32'h0, 0, 0, 4'h0);
      chk("t2.sig", oSig, 32'h04C11DB7);
      check_all("t2.end");

      // 3: flags and opcode folded into D
      start_run(1);
      sample(32'h0, 1, 0, 4'hF);
      chk("t3.sig", oSig, 32'hF0000001);
      chk("t3.zero", 32'(oZeroCnt), 32'd1);
      chk("t3.sign", 32'(oSignCnt), 32'd0);
      check_all("t3.end");

      // 4: empty run, then run with valid gaps
      start_run(0);
      chk("t4.done0", 32'(oDone), 32'd1);
      chk("t4.busy0", 32'(oBusy), 32'd0);
      check_all("t4.empty");
      start_run(3);
      for (int i = 0; i < 3; i++) begin
         sample($urandom, 1'($urandom), 1'($urandom), 4'($urandom));
         check_all("t4.gap_sample");
         tick(); tick();
         chk("t4.done_gap", 32'(oDone), (i == 2) ? 32'd1 : 32'd0);
      end
      check_all("t4.end");

      // 5: start mid-run ignored, then reset mid-run
      start_run(4);
      sample(32'h11, 0, 1, 4'h2);
      sample(32'h22, 1, 0, 4'h3);
      iStart = 1; iCount = CNT_W'(9);
      tick();
      idle_inputs();
      chk("t5.ign_busy", 32'(oBusy), 32'd1);
      check_all("t5.ignored");
      sample(32'h33, 1, 1, 4'h4);
      sample(32'h44, 0, 0, 4'h5);
      chk("t5.samples4", 32'(oSamples), 32'd4);
      check_all("t5.end4");
      start_run(4);
      for (int i = 0; i < 3; i++) sample($urandom, 1'($urandom), 1'($urandom), 4'($urandom));
      rst = 1;
      tick();
      rst = 0;
      chk("t5.rst_sig", oSig, SEED);
      chk("t5.rst_busy", 32'(oBusy), 32'd0);
      chk("t5.rst_samples", 32'(oSamples), 32'd0);
      check_all("t5.rst");

      // 6: valid held beyond run length
      start_run(5);
      for (int i = 0; i < 8; i++) begin
         iValid = 1; iX = $urandom; iZero = 1'($urandom); iSign = 1'($urandom);
         iAluOp = 4'($urandom);
         tick();
         check_all("t6.held");
      end
      idle_inputs();
      chk("t6.samples", 32'(oSamples), 32'd5);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(59) == 0);
         iStart = ($urandom_range(7) == 0);
         iCount = CNT_W'($urandom_range(6));
         iValid = 1'($urandom);
         iX     = $urandom;
         iZero  = 1'($urandom);
         iSign  = 1'($urandom);
         iAluOp = 4'($urandom);
         tick();
         check_all("rand");
      end
      rst = 0;
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
